seg_scan_ctrl: RTL and testbench

//  Time-multiplexing scan controller for a 4-digit common-anode 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Drives one shared BCD decoder, with guard time between digits, leading-zero
// blanking, and a double-buffered load path that commits only at frame boundaries.
module seg_scan_ctrl #(
   parameter int unsigned SLOT_CYC  = 100_000,
   parameter int unsigned GUARD_CYC = 1_000,
   parameter bit          BLANK_LZ  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   output logic        ack,
   output logic        busy,
   output logic [3:0]  bcd_out,
   output logic [3:0]  an_n,
   output logic        dp_n
);

   localparam int unsigned CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

   typedef enum logic {
      GUARD = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         idx_q, idx_d;
   logic [15:0]        disp_q, disp_d;
   logic [3:0]         dpr_q, dpr_d;
   logic [15:0]        pend_q, pend_d;
   logic [3:0]         pend_dp_q, pend_dp_d;
   logic               busy_d, ack_d, dp_n_d;
   logic [3:0]         bcd_d, an_n_d;
   logic               slot_end, frame_end;

   // A digit is dark if its code is not decimal, or if it is a leading zero.
   function automatic logic digit_blanked(input logic [15:0] val, input logic [1:0] k);
      logic res;
      res = (val[{k, 2'b00} +: 4] > 4'd9);
      if (BLANK_LZ) begin
         unique case (k)
            2'd3:    res = res | (val[15:12] == 4'd0);
            2'd2:    res = res | (val[15:8]  == 8'd0);
            2'd1:    res = res | (val[15:4]  == 12'd0);
            default: res = res;
         endcase
      end
      return res;
   endfunction

   // State and output registers; every output is taken straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= GUARD;
         cnt_q     <= '0;
         idx_q     <= 2'd0;
         disp_q    <= 16'd0;
         dpr_q     <= 4'd0;
         pend_q    <= 16'd0;
         pend_dp_q <= 4'd0;
         busy      <= 1'b0;
         ack       <= 1'b0;
         bcd_out   <= 4'd0;
         an_n      <= 4'hF;
         dp_n      <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         disp_q    <= disp_d;
         dpr_q     <= dpr_d;
         pend_q    <= pend_d;
         pend_dp_q <= pend_dp_d;
         busy      <= busy_d;
         ack       <= ack_d;
         bcd_out   <= bcd_d;
         an_n      <= an_n_d;
         dp_n      <= dp_n_d;
      end
   end

   // Next-state: slot timing, load/commit handshake, and outputs for the coming cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      disp_d    = disp_q;
      dpr_d     = dpr_q;
      pend_d    = pend_q;
      pend_dp_d = pend_dp_q;
      busy_d    = busy;
      ack_d     = 1'b0;
      bcd_d     = bcd_out;
      an_n_d    = 4'hF;
      dp_n_d    = 1'b1;

      slot_end  = (cnt_q == CNT_W'(SLOT_CYC - 1));
      frame_end = slot_end && (idx_q == 2'd3);

      cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
      idx_d = slot_end ? idx_q + 2'd1 : idx_q;

      // Commit uses the old pending value; a simultaneous load refills pending.
      if (frame_end && busy) begin
         disp_d = pend_q;
         dpr_d  = pend_dp_q;
         ack_d  = 1'b1;
         busy_d = 1'b0;
      end
      if (load) begin
         pend_d    = digits_in;
         pend_dp_d = dp_in;
         busy_d    = 1'b1;
      end

      unique case (state_q)
         GUARD: if (cnt_d >= CNT_W'(GUARD_CYC)) state_d = SHOW;
         SHOW:  if (slot_end && (GUARD_CYC != 0)) state_d = GUARD;
         default: state_d = GUARD;
      endcase

      // New code presented at slot start so the decoder settles during guard time.
      if (slot_end) bcd_d = disp_d[{idx_d, 2'b00} +: 4];

      if (state_d == SHOW && !digit_blanked(disp_d, idx_d)) begin
         an_n_d = ~(4'b0001 << idx_d);
         dp_n_d = ~dpr_d[idx_d];
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a cycle-numbered reference model.
module tb_seg_scan_ctrl;

   localparam int unsigned SLOT  = 8;
   localparam int unsigned GUARD = 2;
   localparam int unsigned FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digits_in = 16'd0;
   logic [3:0]  dp_in = 4'd0;
   logic        ack, busy, dp_n;
   logic [3:0]  bcd_out, an_n;

   seg_scan_ctrl #(.SLOT_CYC(SLOT), .GUARD_CYC(GUARD), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
      .ack(ack), .busy(busy), .bcd_out(bcd_out), .an_n(an_n), .dp_n(dp_n)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: n = cycles since reset release; everything else follows from it.
   int          n = 0;
   bit          m_valid = 0;
   logic [15:0] m_disp = 16'd0, m_pend = 16'd0;
   logic [3:0]  m_dp = 4'd0, m_pdp = 4'd0;
   logic        m_busy = 1'b0, m_ack = 1'b0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
      end
   endtask

   function automatic bit m_blank(input logic [15:0] v, input int k);
      logic [15:0] upper;
      upper = v >> (4 * k);
      if ((upper & 16'hF) > 16'd9) return 1'b1;
      if (k > 0 && upper == 16'd0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_outputs();
      int k, d;
      logic [3:0] e_an, e_bcd;
      logic       e_dp;
      k = n % SLOT;
      d = (n / SLOT) % 4;
      e_an = 4'hF;
      e_dp = 1'b1;
      e_bcd = 4'((m_disp >> (4 * d)) & 16'hF);
      if (k >= GUARD && !m_blank(m_disp, d)) begin
         e_an = ~(4'b0001 << d);
         e_dp = ~m_dp[d];
      end
      check("an_n", 16'(an_n), 16'(e_an));
      check("dp_n", 16'(dp_n), 16'(e_dp));
      check("ack", 16'(ack), 16'(m_ack));
      check("busy", 16'(busy), 16'(m_busy));
      if (e_an != 4'hF) check("bcd_out", 16'(bcd_out), 16'(e_bcd));
      if (n == 0) check("bcd_out_rst", 16'(bcd_out), 16'd0);
   endtask

   // One clock: check current outputs, apply inputs, advance the model across the edge.
   task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic r);
      @(negedge clk);
      if (m_valid) check_outputs();
      load = ld; digits_in = d; dp_in = p; rst = r;
      @(posedge clk);
      if (r) begin
         n = 0; m_valid = 1;
         m_disp = 16'd0; m_dp = 4'd0; m_pend = 16'd0; m_pdp = 4'd0;
         m_busy = 1'b0; m_ack = 1'b0;
      end else begin
         n++;
         m_ack = 1'b0;
         if (n % FRAME == 0 && m_busy) begin
            m_disp = m_pend; m_dp = m_pdp; m_ack = 1'b1; m_busy = 1'b0;
         end
         if (ld) begin
            m_pend = d; m_pdp = p; m_busy = 1'b1;
         end
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 16'd0, 4'd0, 1'b0);
   endtask

   task automatic align(input int phase);
      for (int i = 0; i < 2 * FRAME && (n % FRAME) != phase; i++) idle(1);
   endtask

   initial begin
      logic [15:0] rv;
      // Reset and idle display of 0 on digit 0
      repeat (3) step(1'b0, 16'd0, 4'd0, 1'b1);
      idle(FRAME + 4);
      // Basic load with decimal point on digit 2
      step(1'b1, 16'h1234, 4'b0100, 1'b0);
      idle(2 * FRAME + 5);
      // Leading-zero blanking
      step(1'b1, 16'h0070, 4'b0011, 1'b0);
      idle(2 * FRAME);
      step(1'b1, 16'h0000, 4'b1111, 1'b0);
      idle(2 * FRAME);
      // Invalid code on digit 1
      step(1'b1, 16'h12A4, 4'b0010, 1'b0);
      idle(2 * FRAME);
      // Back-to-back loads in one frame: single ack, last write wins
      align(5);
      step(1'b1, 16'h1111, 4'b0001, 1'b0);
      idle(5);
      step(1'b1, 16'h2222, 4'b0010, 1'b0);
      idle(2 * FRAME);
      // Load landing on the commit edge
      align(10);
      step(1'b1, 16'h5678, 4'b1000, 1'b0);
      align(FRAME - 1);
      step(1'b1, 16'h9012, 4'b0001, 1'b0);
      idle(2 * FRAME + 3);
      // Reset while busy during digit 2 SHOW
      align(4);
      step(1'b1, 16'h9876, 4'b1111, 1'b0);
      align(2 * SLOT + 3);
      check("busy_before_rst", 16'(m_busy), 16'(busy));
      step(1'b0, 16'd0, 4'd0, 1'b1);
      idle(2 * FRAME);
      // Random traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rv = 16'd0;
         for (int j = 0; j < 4; j++)
            rv[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         step(($urandom_range(0, 11) == 0), rv, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 599) == 0));
      end
      idle(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
